gmii_rx_interface: RTL and testbench
====================================

Name: gmii_rx_interface

Overview:
- GMII receive-side counterpart of the transmit interface.
- Monitors gmii_rx_data/gmii_rx_dv/gmii_rx_er, validates and strips the 0x55 preamble and 0xD5 SFD, and writes frame bytes into the downstream byte FIFO.
- At end of frame, publishes the byte count and an error flag via a level ready/ack handshake. The ack is synchronized through 3 flops, matching the word_count_ready/ack scheme used on the transmit side.

Parameters:
MAX_LEN, 1518, maximum frame bytes written to FIFO; bytes beyond are discarded and flagged
MIN_PREAMBLE, 1, minimum count of 0x55 bytes required before SFD

Ports:
clk  input  1  system clock; GMII rx signals already synchronous to it
rst_n  input  1  asynchronous active-low reset
gmii_rx_data  input  8  GMII receive data
gmii_rx_dv  input  1  GMII receive data valid
gmii_rx_er  input  1  GMII receive error
fifo_full  input  1  downstream FIFO full
fifo_wr  output  1  FIFO write strobe, one byte per cycle
fifo_data  output  8  FIFO write data
word_count  output  11  bytes written for reported frame
frame_error  output  1  reported frame had an error (valid with word_count)
word_count_ready  output  1  report pending
word_count_ack  input  1  consumer ack (may be from another domain)
drop_count  output  8  frames dropped because handshake was busy, saturating

Behaviour:
- Reset (rst_n low, async): all outputs 0; state S_IDLE; internal counters, input and sync registers cleared.
- Input stage: gmii_rx_data/dv/er registered once (d_r, dv_r, er_r). The FSM acts on the registered values. fifo_wr/fifo_data are registered, so a body byte on the pins appears on fifo_data 2 cycles later.
- Ack sync: ack_sync <= {ack_sync[1:0], word_count_ack}.
- Handshake:
  - word_count_ready rises with word_count/frame_error latched.
  - It falls the cycle after ack_sync[2] is seen high.
  - busy = word_count_ready | ack_sync[2]. A new report is allowed only when busy is 0.
- S_IDLE:
  - dv_r=1, d_r=0x55, busy=0 -> S_PREAMBLE, pre_cnt=1.
  - dv_r=1 with busy=1 -> S_DROP, drop_count+1, saturating at 255.
  - dv_r=1 with any other byte -> S_DROP, no drop_count increment.
- S_PREAMBLE:
  - d_r=0x55 -> pre_cnt+1, saturating at 7.
  - d_r=0xD5 and pre_cnt>=MIN_PREAMBLE -> S_BODY, byte_cnt=0, err=0.
  - Any other byte, dv_r=0, or er_r=1 -> S_DROP if dv_r=1, else S_IDLE. No FIFO write, no report.
- S_BODY, per dv_r=1 cycle:
  - er_r=1 -> err=1. The byte is still written.
  - byte_cnt<MAX_LEN and fifo_full=0 -> fifo_wr=1, fifo_data=d_r, byte_cnt+1.
  - byte_cnt==MAX_LEN -> byte discarded, err=1.
  - fifo_full=1 -> byte discarded, err=1, byte_cnt unchanged.
  - dv_r=0 -> S_REPORT. fifo_wr is 0 in this cycle.
- S_REPORT, one cycle:
  - byte_cnt>0 -> word_count<=byte_cnt, frame_error<=err, word_count_ready<=1.
  - byte_cnt==0 -> no report.
  - Always -> S_IDLE.
- S_DROP: no writes; wait for dv_r=0 -> S_IDLE.
- fifo_wr is high only in S_BODY cycles that meet the write rule; otherwise 0 every cycle. fifo_data holds its last value when fifo_wr is low.
- byte_cnt is 11 bits; MAX_LEN must be <= 2047.
- Minimum separation between a report and the next accepted frame is the ack round trip. A frame starting while busy is dropped in full, never truncated.
- Async reset mid-frame: immediate return to idle, with outputs 0 and no partial report. Frame bytes already written to the FIFO are the consumer's responsibility; the consumer resets with us.

Test Plan:
- Frame of 7x0x55, 0xD5, then 64 bytes 0x00..0x3F with dv -> 64 fifo_wr pulses carrying 0x00..0x3F in order, the first 2 cycles after the first body byte on the pins; then word_count=64, frame_error=0, ready=1; ack high -> ready falls within 4 cycles of ack rising.
- Preamble corrupted (0x55,0x55,0x12,...) -> zero fifo_wr, no ready, FSM idle after dv falls; a following valid 10-byte frame reports word_count=10.
- 20-byte body with gmii_rx_er high on byte 5 -> 20 writes, word_count=20, frame_error=1.
- 1600-byte body, MAX_LEN=1518 -> exactly 1518 writes, word_count=1518, frame_error=1.
- Second frame starts while ack is withheld after the first report -> second frame produces no writes, drop_count=1, word_count still holds the first count; after the ack cycle completes, a third frame reports normally.
- fifo_full held for 3 body cycles of a 16-byte frame -> 13 writes, word_count=13, frame_error=1.
- rst_n pulsed low mid-body -> outputs 0 asynchronously, no report; the next frame is handled normally.

Source files
------------

// File: rtl/gmii_rx_interface.sv
// rtl/gmii_rx_interface.sv - GMII receive front end: strips preamble/SFD, streams frame bytes to a FIFO, reports count via ready/ack
module gmii_rx_interface #(
    parameter int MAX_LEN      = 1518,
    parameter int MIN_PREAMBLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_rx_data,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [7:0]  fifo_data,
    output logic [10:0] word_count,
    output logic        frame_error,
    output logic        word_count_ready,
    input  logic        word_count_ack,
    output logic [7:0]  drop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_BODY,
        S_REPORT,
        S_DROP
    } state_t;

    localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);
    localparam logic [2:0]  MIN_PRE = 3'(MIN_PREAMBLE);

    state_t      state;
    logic [7:0]  d_r;
    logic        dv_r;
    logic        er_r;
    logic [2:0]  ack_sync;
    logic [2:0]  pre_cnt;
    logic [10:0] byte_cnt;
    logic        err;
    logic        busy;

    // A report is still outstanding until the synchronized ack has also dropped.
    assign busy = word_count_ready | ack_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            d_r              <= 8'h00;
            dv_r             <= 1'b0;
            er_r             <= 1'b0;
            ack_sync         <= 3'b000;
            pre_cnt          <= 3'd0;
            byte_cnt         <= 11'd0;
            err              <= 1'b0;
            fifo_wr          <= 1'b0;
            fifo_data        <= 8'h00;
            word_count       <= 11'd0;
            frame_error      <= 1'b0;
            word_count_ready <= 1'b0;
            drop_count       <= 8'h00;
        end else begin
            d_r      <= gmii_rx_data;
            dv_r     <= gmii_rx_dv;
            er_r     <= gmii_rx_er;
            ack_sync <= {ack_sync[1:0], word_count_ack};
            fifo_wr  <= 1'b0;

            if (ack_sync[2]) begin
                word_count_ready <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (dv_r) begin
                        if (busy) begin
                            state <= S_DROP;
                            if (drop_count != 8'hFF) begin
                                drop_count <= drop_count + 8'd1;
                            end
                        end else if (d_r == 8'h55) begin
                            state   <= S_PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end

                S_PREAMBLE: begin
                    if (dv_r && !er_r && d_r == 8'h55) begin
                        if (pre_cnt != 3'd7) begin
                            pre_cnt <= pre_cnt + 3'd1;
                        end
                    end else if (dv_r && !er_r && d_r == 8'hD5 && pre_cnt >= MIN_PRE) begin
                        state    <= S_BODY;
                        byte_cnt <= 11'd0;
                        err      <= 1'b0;
                    end else begin
                        state <= dv_r ? S_DROP : S_IDLE;
                    end
                end

                S_BODY: begin
                    if (!dv_r) begin
                        state <= S_REPORT;
                    end else begin
                        if (er_r) begin
                            err <= 1'b1;
                        end
                        // Discarded bytes (FIFO full or overlength) mark the frame bad.
                        if (fifo_full || byte_cnt == MAX_CNT) begin
                            err <= 1'b1;
                        end else begin
                            fifo_wr   <= 1'b1;
                            fifo_data <= d_r;
                            byte_cnt  <= byte_cnt + 11'd1;
                        end
                    end
                end

                S_REPORT: begin
                    if (byte_cnt != 11'd0) begin
                        word_count       <= byte_cnt;
                        frame_error      <= err;
                        word_count_ready <= 1'b1;
                    end
                    state <= S_IDLE;
                end

                S_DROP: begin
                    if (!dv_r) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_interface.sv
// tb/tb_gmii_rx_interface.sv - scoreboard bench for gmii_rx_interface with frame-level reference model
module tb_gmii_rx_interface;

    localparam int MAX_LEN      = 1518;
    localparam int MIN_PREAMBLE = 1;

    logic        clk;
    logic        rst_n;
    logic [7:0]  gmii_rx_data;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic [10:0] word_count;
    logic        frame_error;
    logic        word_count_ready;
    logic        word_count_ack;
    logic [7:0]  drop_count;

    gmii_rx_interface #(.MAX_LEN(MAX_LEN), .MIN_PREAMBLE(MIN_PREAMBLE)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .gmii_rx_data     (gmii_rx_data),
        .gmii_rx_dv       (gmii_rx_dv),
        .gmii_rx_er       (gmii_rx_er),
        .fifo_full        (fifo_full),
        .fifo_wr          (fifo_wr),
        .fifo_data        (fifo_data),
        .word_count       (word_count),
        .frame_error      (frame_error),
        .word_count_ready (word_count_ready),
        .word_count_ack   (word_count_ack),
        .drop_count       (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int cyc;

    logic [7:0] pre_q[$];
    logic [7:0] body_q[$];
    bit         er_q[$];
    bit         full_q[$];

    logic [7:0] exp_bytes[$];
    int         rep_wc[$];
    int         rep_fe[$];
    int         drop_exp;
    int         last_wc;
    bit         busy_exp;
    bit         withhold;
    bit         ignore_wr;
    bit         lat_pending;
    int         lat_t0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: decides the fate of a whole frame from its byte lists.
    task automatic model_frame(output bit accepted);
        int  np;
        bit  ok;
        int  cnt;
        bit  err;
        np = pre_q.size();
        accepted = 0;
        if (busy_exp) begin
            if (drop_exp < 255) drop_exp++;
            return;
        end
        ok = (np >= 1 + MIN_PREAMBLE) && (pre_q[np-1] == 8'hD5);
        for (int i = 0; i < np - 1; i++) if (pre_q[i] != 8'h55) ok = 0;
        if (!ok) return;
        accepted = 1;
        cnt = 0;
        err = 0;
        for (int i = 0; i < body_q.size(); i++) begin
            if (er_q[i]) err = 1;
            if (full_q[i]) err = 1;
            else if (cnt == MAX_LEN) err = 1;
            else begin
                exp_bytes.push_back(body_q[i]);
                cnt++;
            end
        end
        if (cnt > 0) begin
            rep_wc.push_back(cnt);
            rep_fe.push_back(int'(err));
            last_wc = cnt;
        end
    endtask

    task automatic build_frame(input int npre, input int len, input bit incr,
                               input int er_at, input int full_from, input int full_n);
        pre_q.delete(); body_q.delete(); er_q.delete(); full_q.delete();
        for (int i = 0; i < npre; i++) pre_q.push_back(8'h55);
        pre_q.push_back(8'hD5);
        for (int i = 0; i < len; i++) begin
            body_q.push_back(incr ? 8'(i) : 8'($urandom));
            er_q.push_back(i == er_at);
            full_q.push_back(i >= full_from && i < full_from + full_n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_fifo_wr", int'(fifo_wr), 0);
        check("rst_fifo_data", int'(fifo_data), 0);
        check("rst_word_count", int'(word_count), 0);
        check("rst_frame_error", int'(frame_error), 0);
        check("rst_ready", int'(word_count_ready), 0);
        check("rst_drop_count", int'(drop_count), 0);
        drop_exp = 0;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        fifo_full  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // abort_at >= 0 pulses reset asynchronously while that cycle's byte is on the pins.
    task automatic send_frame(input int abort_at);
        int  np;
        int  nb;
        int  total;
        int  j;
        bit  accepted;
        np = pre_q.size();
        nb = body_q.size();
        total = np + nb;
        accepted = 0;
        if (abort_at < 0) model_frame(accepted);
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            j = c - 1 - np;
            fifo_full = (j >= 0 && j < nb) ? full_q[j] : 1'b0;
            if (c < total) begin
                gmii_rx_dv   = 1'b1;
                gmii_rx_data = (c < np) ? pre_q[c] : body_q[c - np];
                gmii_rx_er   = (c >= np) ? er_q[c - np] : 1'b0;
                if (c == np && accepted && !full_q[0]) begin
                    lat_t0 = cyc;
                    lat_pending = 1;
                end
            end else begin
                gmii_rx_dv   = 1'b0;
                gmii_rx_er   = 1'b0;
                gmii_rx_data = 8'h00;
            end
            if (c == abort_at) begin
                #3;
                do_reset();
                return;
            end
        end
        @(negedge clk);
        fifo_full = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        repeat (5) @(posedge clk);
        n = 0;
        while ((word_count_ready || word_count_ack) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) check("idle_timeout", 1, 0);
        repeat (6) @(posedge clk);
    endtask

    task automatic monitor();
        bit ready_q;
        ready_q = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ready_q = 0;
            end else begin
                if (fifo_wr && !ignore_wr) begin
                    if (lat_pending) begin
                        check("first_byte_latency", cyc - lat_t0, 2);
                        lat_pending = 0;
                    end
                    if (exp_bytes.size() == 0) check("unexpected_fifo_wr", 1, 0);
                    else check("fifo_data", int'(fifo_data), int'(exp_bytes.pop_front()));
                end
                if (word_count_ready && !ready_q) begin
                    if (rep_wc.size() == 0) begin
                        check("unexpected_report", 1, 0);
                    end else begin
                        check("word_count", int'(word_count), rep_wc.pop_front());
                        check("frame_error", int'(frame_error), rep_fe.pop_front());
                    end
                end
                ready_q = word_count_ready;
            end
        end
    endtask

    task automatic consumer();
        int n;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && word_count_ready && !withhold) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(negedge clk);
                word_count_ack = 1'b1;
                n = 0;
                while (word_count_ready && n < 10) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("ack_to_ready_fall", int'(n <= 4), 1);
                @(negedge clk);
                word_count_ack = 1'b0;
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        drop_exp = 0; last_wc = 0; busy_exp = 0; withhold = 0;
        ignore_wr = 0; lat_pending = 0; lat_t0 = 0;
        gmii_rx_data = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
        fifo_full = 1'b0; word_count_ack = 1'b0; rst_n = 1'b1;
        #2;
        do_reset();
        fork
            forever begin @(posedge clk); cyc++; end
            monitor();
            consumer();
            begin
                #2000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        build_frame(7, 64, 1, -1, 0, 0);
        send_frame(-1);
        wait_idle();

        pre_q.delete(); body_q.delete(); er_q.delete(); full_q.delete();
        pre_q = '{8'h55, 8'h55, 8'h12};
        for (int i = 0; i < 6; i++) begin
            body_q.push_back(8'(i + 1)); er_q.push_back(0); full_q.push_back(0);
        end
        send_frame(-1);
        wait_idle();
        build_frame(3, 10, 0, -1, 0, 0);
        send_frame(-1);
        wait_idle();

        build_frame(7, 20, 0, 5, 0, 0);
        send_frame(-1);
        wait_idle();

        build_frame(7, 1600, 1, -1, 0, 0);
        send_frame(-1);
        wait_idle();

        build_frame(7, 16, 0, -1, 4, 3);
        send_frame(-1);
        wait_idle();

        build_frame(2, 0, 0, -1, 0, 0);
        send_frame(-1);
        wait_idle();

        withhold = 1;
        build_frame(7, 12, 0, -1, 0, 0);
        send_frame(-1);
        repeat (5) @(posedge clk);
        #1;
        check("ready_held", int'(word_count_ready), 1);
        busy_exp = 1;
        build_frame(7, 30, 0, -1, 0, 0);
        send_frame(-1);
        busy_exp = 0;
        repeat (3) @(posedge clk);
        #1;
        check("word_count_kept", int'(word_count), last_wc);
        check("drop_count", int'(drop_count), drop_exp);
        withhold = 0;
        wait_idle();
        build_frame(5, 25, 0, -1, 0, 0);
        send_frame(-1);
        wait_idle();
        check("drop_count_before_reset", int'(drop_count), 1);

        ignore_wr = 1;
        build_frame(7, 30, 0, -1, 0, 0);
        send_frame(18);
        ignore_wr = 0;
        lat_pending = 0;
        repeat (10) @(posedge clk);
        #1;
        check("no_report_after_reset", int'(word_count_ready), 0);

        for (int f = 0; f < 8; f++) begin
            build_frame($urandom_range(1, 7), $urandom_range(1, 80), 0,
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1,
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : 1000,
                        $urandom_range(1, 4));
            send_frame(-1);
            wait_idle();
        end

        repeat (20) @(posedge clk);
        #1;
        check("fifo_queue_drained", exp_bytes.size(), 0);
        check("report_queue_drained", rep_wc.size(), 0);
        check("final_drop_count", int'(drop_count), drop_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
